dm11a88_scan: RTL and testbench
===============================

# dm11a88_scan

Row-scan frame source for the DM11A88 8x8 LED matrix. It holds a double-buffered 8x8 pixel frame and emits one 16-bit row word per scan slot: the upper byte is the column pattern and the lower byte is the row select. Words go over a valid/ready handshake to the DM11A88 serial shifter, which clocks them out on di/clk/lat. Pixel writes land in the back buffer, and a requested buffer swap takes effect only at a frame boundary, so the display never tears.

## Interface

Parameters:
- DWELL_CYCLES, 50000: idle clk_50m cycles between an accepted row word and the next offered word (≥1).
- ROWS, 8: scan rows. Fixed at 8; comes from the package.
- COLS, 8: columns. Fixed at 8; comes from the package.

Ports:
- clk_50m  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- wr_en  in  1  write one row of the back buffer this cycle.
- wr_row  in  3  row index for the write.
- wr_data  in  8  pixel bits for the write; bit c is column c, 1 = LED lit.
- swap_req  in  1  one-cycle pulse requesting a front/back swap at the next frame end.
- word  out  16  {~col_pixels[7:0], row_sel_n[7:0]}; row_sel_n is one-cold, bit r low selects row r.
- word_valid  out  1  word is offered.
- word_ready  in  1  shifter accepts word when high with word_valid.
- frame_end  out  1  one-cycle pulse in the cycle row 7's word is accepted.
- swap_ack  out  1  one-cycle pulse in the cycle a pending swap is applied.

## Operation

- Storage: two 8x8-bit buffers, front (scanned) and back (written). front_sel is 1 bit.
- Writes: in a cycle with wr_en, back[wr_row] ← wr_data.
  - Back is taken from front_sel as registered before that edge. A write in the swap cycle therefore lands in the buffer that becomes front.
- swap_req sets swap_pending.
  - Repeated requests before the frame end collapse into a single swap.
  - swap_req in the same cycle as a frame end sets pending for the next frame; it does not swap now.
- State machine (package enum):
  - S_DWELL: dwell counter counts up from 0. When it reaches DWELL_CYCLES−1, go to S_OFFER and assert word_valid.
  - S_OFFER: word = {~front[row], ~(8'b1<<row)}. Hold until word_valid && word_ready.
    - On accept: counter ← 0, go to S_DWELL.
    - If row==7: row ← 0, frame_end=1, and if swap_pending then front_sel flips, swap_pending ← 0, swap_ack=1.
    - Otherwise row ← row+1.
- Row counter is 3 bits and wraps 7→0. Dwell counter width is $clog2(DWELL_CYCLES).
- word must stay constant while word_valid && !word_ready. word_ready with word_valid low is ignored.

## Timing

- Reset values: word=16'hFFFF (all off), word_valid=0, frame_end=0, swap_ack=0, row=0, front_sel=0, swap_pending=0, both buffers all-zero, state S_DWELL, counter 0.
- After rst_n deasserts, word_valid rises at the DWELL_CYCLES-th rising edge.
- Offer-to-next-offer time is the accept cycle plus DWELL_CYCLES cycles.
- With word_ready held high, word_valid is high for exactly one cycle per row. Frame period = 8·(DWELL_CYCLES+1).
- word is registered: it updates on the edge entering S_OFFER and shows 16'hFFFF while in S_DWELL.
- A swap becomes visible starting with the row-0 word of the next frame.
- rst_n low mid-offer: the offer is dropped, all state returns to reset values, and buffer contents are cleared.

## Structure

- Package dm11a88_pkg: ROWS, COLS, typedef logic [15:0] word_t, OFF_WORD = 16'hFFFF, typedef enum {S_DWELL, S_OFFER} scan_state_t.
- Sub-module dm11a88_fbuf: the double buffer.
  - Ports: write port, a front_sel input, and a combinational read of front[row].
  - It holds the two buffers and clears them on rst_n.
- The top level holds the FSM, the counters, and the swap logic.

## Test plan

- Reset, DWELL_CYCLES=4, ready held high, no writes → valid pulses every 5 cycles, words 16'hFFFE, FFFD, FFFB … FF7F then FFFE, frame_end on the FF7F accept.
- Write row 2 = 8'hA5, swap_req, run one frame → after swap_ack, the row-2 word = 16'h5AFB; the frame before the swap shows FFFB.
- Backpressure: ready low for 10 cycles during the row-3 offer → word holds 16'hFFF7 and valid stays high; the next offer comes exactly DWELL_CYCLES+1 cycles after the accept.
- swap_req in the same cycle as frame_end → no swap_ack at that edge; swap_ack at the following frame end.
- Write in the swap_ack cycle with row 0 = 8'h01 → the next frame's row-0 word = 16'hFEFE.
- rst_n low for 1 cycle during an offer of row 5 → next cycle word=16'hFFFF, valid=0, and the next offer is row 0 = 16'hFFFE.

Source files
------------

// File: rtl/dm11a88_pkg.sv
// Shared types and constants for the DM11A88 row-scan frame source.
// The matrix geometry is fixed at 8x8; the row word is {~columns, one-cold row select}.
package dm11a88_pkg;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int ROW_W = $clog2(ROWS);

  typedef logic [15:0] word_t;

  localparam word_t OFF_WORD = 16'hFFFF;

  typedef enum logic {S_DWELL, S_OFFER} scan_state_t;

  // Both halves are active-low at the shifter: a 0 lights a column / selects a row.
  function automatic word_t row_word(input logic [COLS-1:0] cols, input logic [ROW_W-1:0] row);
    return {~cols, ~(8'b1 << row)};
  endfunction

endpackage

// File: rtl/dm11a88_fbuf.sv
// Double-buffered 8x8 frame store: writes go to the back half, reads come combinationally from the front half.
// Contents clear on synchronous reset; the front/back roles follow front_sel.
module dm11a88_fbuf
  import dm11a88_pkg::*;
(
  input  logic             clk_50m,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [COLS-1:0]  wr_data,
  input  logic             front_sel,
  input  logic [ROW_W-1:0] rd_row,
  output logic [COLS-1:0]  rd_data
);

  logic [COLS-1:0] mem [2][ROWS];

  // front_sel is the pre-edge value, so a write in the swap cycle lands in the new front.
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < ROWS; r++) begin
          mem[b][r] <= '0;
        end
      end
    end else if (wr_en) begin
      mem[~front_sel][wr_row] <= wr_data;
    end
  end

  assign rd_data = mem[front_sel][rd_row];

endmodule

// File: rtl/dm11a88_scan.sv
// Row-scan source: one row word per slot, offered DWELL_CYCLES cycles after the previous accept.
// The offered word holds while ready is low; buffer swaps are deferred to the frame boundary.
module dm11a88_scan
  import dm11a88_pkg::*;
#(
  parameter int DWELL_CYCLES = 50000
) (
  input  logic            clk_50m,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [2:0]      wr_row,
  input  logic [7:0]      wr_data,
  input  logic            swap_req,
  output word_t           word,
  output logic            word_valid,
  input  logic            word_ready,
  output logic            frame_end,
  output logic            swap_ack
);

  localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL_CYCLES - 1);

  scan_state_t      state;
  logic [CW-1:0]    cnt;
  logic [ROW_W-1:0] row;
  logic             front_sel;
  logic             swap_pending;
  logic [COLS-1:0]  front_row;
  logic             accept;

  dm11a88_fbuf u_fbuf (
    .clk_50m   (clk_50m),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_row    (wr_row),
    .wr_data   (wr_data),
    .front_sel (front_sel),
    .rd_row    (row),
    .rd_data   (front_row)
  );

  assign accept    = word_valid && word_ready;
  assign frame_end = accept && (row == ROW_W'(ROWS - 1));
  assign swap_ack  = frame_end && swap_pending;

  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      state        <= S_DWELL;
      cnt          <= '0;
      row          <= '0;
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
      word         <= OFF_WORD;
      word_valid   <= 1'b0;
    end else begin
      // A request coinciding with the frame end is kept for the following frame.
      if (frame_end) begin
        swap_pending <= swap_req;
      end else begin
        swap_pending <= swap_pending | swap_req;
      end

      if (swap_ack) begin
        front_sel <= ~front_sel;
      end

      case (state)
        S_DWELL: begin
          if (cnt == CNT_LAST) begin
            state      <= S_OFFER;
            word_valid <= 1'b1;
            word       <= row_word(front_row, row);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_OFFER: begin
          if (word_ready) begin
            state      <= S_DWELL;
            word_valid <= 1'b0;
            word       <= OFF_WORD;
            cnt        <= '0;
            row        <= row + ROW_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm11a88_scan.sv
// Randomized and directed bench for dm11a88_scan against an event-level reference model.
// The model tracks pixel arrays, swap intent and slot timing, and predicts every output each cycle.
module tb_dm11a88_scan;

  localparam int D = 4;

  logic        clk_50m = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_row = '0;
  logic [7:0]  wr_data = '0;
  logic        swap_req = 1'b0;
  logic        word_ready = 1'b0;
  logic [15:0] word;
  logic        word_valid;
  logic        frame_end;
  logic        swap_ack;

  dm11a88_scan #(.DWELL_CYCLES(D)) dut (
    .clk_50m    (clk_50m),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_row     (wr_row),
    .wr_data    (wr_data),
    .swap_req   (swap_req),
    .word       (word),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .frame_end  (frame_end),
    .swap_ack   (swap_ack)
  );

  always #5 clk_50m = ~clk_50m;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: pixels per buffer, which buffer is shown, swap intent, slot timing.
  logic [7:0] m_buf [2][8];
  bit         m_front;
  bit         m_pend;
  bit         m_offer;
  int         m_row;
  int         m_idle;

  logic [15:0] obs_word;
  bit          obs_valid, obs_fe, obs_sa;
  logic [15:0] seen [$];
  int          fe_cnt;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic void model_reset();
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 8; r++)
        m_buf[b][r] = 8'h00;
    m_front = 0;
    m_pend  = 0;
    m_offer = 0;
    m_row   = 0;
    m_idle  = 0;
  endfunction

  function automatic logic [15:0] exp_word();
    int px, w;
    if (!m_offer) return 16'hFFFF;
    px = int'(m_buf[m_front][m_row]);
    w  = (255 - px) * 256 + (255 - (1 << m_row));
    return 16'(w);
  endfunction

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic step(input bit rst, input bit en, input logic [2:0] r, input logic [7:0] d,
                      input bit sw, input bit rdy);
    bit acc, fe, sa;
    @(negedge clk_50m);
    rst_n = rst; wr_en = en; wr_row = r; wr_data = d; swap_req = sw; word_ready = rdy;
    #1;
    obs_word  = word;
    obs_valid = word_valid;
    obs_fe    = frame_end;
    obs_sa    = swap_ack;
    acc = m_offer && rdy;
    fe  = acc && (m_row == 7);
    sa  = fe && m_pend;
    check("word_valid", 16'(word_valid), 16'(m_offer));
    check("word", word, exp_word());
    check("frame_end", 16'(frame_end), 16'(fe));
    check("swap_ack", 16'(swap_ack), 16'(sa));
    if (word_valid) seen.push_back(word);
    if (frame_end) fe_cnt++;
    if (!rst) begin
      model_reset();
    end else begin
      if (en) m_buf[m_front ? 0 : 1][r] = d;
      if (fe) begin
        if (m_pend) m_front = !m_front;
        m_pend = sw;
      end else begin
        m_pend = m_pend || sw;
      end
      if (acc) begin
        m_offer = 0;
        m_idle  = 0;
        m_row   = (m_row + 1) % 8;
      end else if (!m_offer) begin
        m_idle++;
        if (m_idle == D) m_offer = 1;
      end
    end
  endtask

  // Run with ready high until the model says row r is about to be on offer.
  task automatic seek(input int r);
    int k = 0;
    while (!(m_offer && m_row == r) && k < 200) begin
      step(1, 0, 3'd0, 8'h00, 0, 1);
      k++;
    end
    if (k >= 200) check("seek_timeout", 16'(k), 16'(0));
  endtask

  initial begin
    logic [15:0] pre_row2;
    int g;

    model_reset();
    @(posedge clk_50m);
    @(posedge clk_50m);

    // Reset state and the plain scan sequence on an empty frame.
    step(0, 0, 3'd0, 8'h00, 0, 1);
    check("reset_word", obs_word, 16'hFFFF);
    check("reset_valid", 16'(obs_valid), 16'h0000);
    seen.delete();
    fe_cnt = 0;
    for (int i = 0; i < 45; i++) step(1, 0, 3'd0, 8'h00, 0, 1);
    check("scan_count", 16'(seen.size()), 16'(9));
    for (int i = 0; i < 9 && i < seen.size(); i++)
      check($sformatf("scan_word%0d", i), seen[i], 16'hFF00 | 16'(255 - (1 << (i % 8))));
    check("scan_frame_end_cnt", 16'(fe_cnt), 16'(1));

    // Back-buffer write plus swap: old frame shows blank row 2, the next shows A5.
    step(1, 1, 3'd2, 8'hA5, 1, 1);
    pre_row2 = 16'h0000;
    g = 0;
    while (!obs_sa && g < 100) begin
      step(1, 0, 3'd0, 8'h00, 0, 1);
      if (obs_valid && obs_word[7:0] == 8'hFB) pre_row2 = obs_word;
      g++;
    end
    check("swap_ack_seen", 16'(obs_sa), 16'h0001);
    check("pre_swap_row2", pre_row2, 16'hFFFB);
    seek(2);
    step(1, 0, 3'd0, 8'h00, 0, 0);
    check("post_swap_row2", obs_word, 16'h5AFB);

    // Backpressure on row 3, then the dwell gap after the accept.
    seek(3);
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 3'd0, 8'h00, 0, 0);
      check("bp_hold_word", obs_word, 16'hFFF7);
      check("bp_hold_valid", 16'(obs_valid), 16'h0001);
    end
    step(1, 0, 3'd0, 8'h00, 0, 1);
    g = 0;
    do begin
      step(1, 0, 3'd0, 8'h00, 0, 1);
      g++;
    end while (!obs_valid && g < 50);
    check("bp_gap", 16'(g), 16'(D + 1));

    // swap_req coinciding with frame_end defers the swap one frame.
    seek(7);
    step(1, 0, 3'd0, 8'h00, 1, 1);
    check("coincide_fe", 16'(obs_fe), 16'h0001);
    check("coincide_no_ack", 16'(obs_sa), 16'h0000);
    seek(7);
    step(1, 0, 3'd0, 8'h00, 0, 1);
    check("deferred_ack", 16'(obs_sa), 16'h0001);

    // Write in the swap_ack cycle goes into the frame that becomes visible.
    step(1, 0, 3'd0, 8'h00, 1, 1);
    seek(7);
    step(1, 1, 3'd0, 8'h01, 0, 1);
    check("ack_cycle_write_ack", 16'(obs_sa), 16'h0001);
    seek(0);
    step(1, 0, 3'd0, 8'h00, 0, 0);
    check("ack_cycle_write_row0", obs_word, 16'hFEFE);

    // Reset during the row-5 offer.
    seek(5);
    step(1, 0, 3'd0, 8'h00, 0, 0);
    check("pre_reset_valid", 16'(obs_valid), 16'h0001);
    step(0, 0, 3'd0, 8'h00, 0, 0);
    step(1, 0, 3'd0, 8'h00, 0, 1);
    check("post_reset_valid", 16'(obs_valid), 16'h0000);
    check("post_reset_word", obs_word, 16'hFFFF);
    g = 0;
    do begin
      step(1, 0, 3'd0, 8'h00, 0, 1);
      g++;
    end while (!obs_valid && g < 50);
    check("post_reset_first", obs_word, 16'hFFFE);

    // Random traffic, continuously compared against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 499) != 0,
           $urandom_range(0, 4) == 0,
           3'($urandom_range(0, 7)),
           8'($urandom_range(0, 255)),
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) < 7);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
